// File: rtl/hog_block_assembler_pkg.sv
// Shared constants and types for the HOG block assembler.
package hog_pkg;

  localparam int HISTOGRAM_BINS = 9;
  localparam int BIN_ADDR_W     = 4;
  localparam int VALUE_W        = 18;
  localparam int BLOCK_LEN      = 36;
  localparam int SUM_W          = 24;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when a bin index addresses the final bin of a cell.
  function automatic logic is_last_bin(input logic [BIN_ADDR_W-1:0] bin);
    return bin == BIN_ADDR_W'(HISTOGRAM_BINS - 1);
  endfunction

endpackage

// File: rtl/hog_block_assembler_cell_row_ram.sv
// One cell-row buffer: simple dual-port RAM with a registered read port.
module cell_row_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 18
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] dout_r;

  // Write port: store one bin value per enabled cycle.
  always_ff @(posedge pclk) begin
    if (we) begin
      mem_r[wr_addr] <= din;
    end
  end

  // Read port: data appears the cycle after the read request.
  always_ff @(posedge pclk) begin
    if (re) begin
      dout_r <= mem_r[rd_addr];
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/hog_block_assembler.sv
// Collects 9-bin cell histograms row by row into two ping-pong row buffers and,
// after every row except the first of a frame, streams out the overlapping
// 2x2-cell blocks of the previous and current rows with per-block L1 sums.
module hog_block_assembler
  import hog_pkg::*;
#(
  parameter int CELLS_IN_LINE = 8,
  parameter int CELL_ROWS     = 16
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [VALUE_W-1:0]   histValueIn,
  input  logic                 deIn,
  output logic [VALUE_W-1:0]   valueOut,
  output logic                 deOut,
  output logic                 blockStart,
  output logic                 blockEnd,
  output logic [SUM_W-1:0]     blockSumOut,
  output logic                 busy,
  output logic                 overrunErr
);

  localparam int CELL_W = (CELLS_IN_LINE > 2) ? $clog2(CELLS_IN_LINE) : 1;
  localparam int ROW_W  = (CELL_ROWS > 2) ? $clog2(CELL_ROWS) : 1;
  localparam int ADDR_W = CELL_W + BIN_ADDR_W;

  localparam logic [CELL_W-1:0] LAST_CELL  = CELL_W'(CELLS_IN_LINE - 1);
  localparam logic [CELL_W-1:0] LAST_BLOCK = CELL_W'(CELLS_IN_LINE - 2);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(CELL_ROWS - 1);

  // Input-side indexing
  logic [BIN_ADDR_W-1:0] bin_r;
  logic [CELL_W-1:0]     cell_r;
  logic [ROW_W-1:0]      row_r;
  logic                  row_done_s;

  // Emission FSM
  state_t                state_r;
  logic [CELL_W-1:0]     j_r;
  logic [1:0]            q_r;
  logic [BIN_ADDR_W-1:0] b_r;
  logic                  cur_sel_r;
  logic                  busy_r;
  logic                  overrun_r;
  logic                  trigger_s;
  logic                  final_s;
  logic                  rd_en_s;
  logic                  rd_sel_s;
  logic [CELL_W-1:0]     rd_cell_s;
  logic [ADDR_W-1:0]     rd_addr_s;

  // Read pipeline and outputs
  logic                  p1_valid_r;
  logic                  p1_sel_r;
  logic                  p1_first_r;
  logic                  p1_last_r;
  logic [VALUE_W-1:0]    dout_a_s;
  logic [VALUE_W-1:0]    dout_b_s;
  logic [VALUE_W-1:0]    rd_data_s;
  logic [SUM_W-1:0]      sum_s;
  logic [SUM_W-1:0]      acc_r;
  logic [VALUE_W-1:0]    value_r;
  logic                  de_r;
  logic                  start_r;
  logic                  end_r;
  logic [SUM_W-1:0]      sum_out_r;

  // Row-completion detect on the final bin of the final cell.
  always_comb begin
    if (deIn && is_last_bin(bin_r) && (cell_r == LAST_CELL)) begin
      row_done_s = 1'b1;
    end else begin
      row_done_s = 1'b0;
    end
  end

  // Input counters: bin fastest, then cell, then row (wrapping per frame).
  always_ff @(posedge pclk) begin
    if (reset) begin
      bin_r  <= '0;
      cell_r <= '0;
      row_r  <= '0;
    end else if (deIn) begin
      if (is_last_bin(bin_r)) begin
        bin_r <= '0;
        if (cell_r == LAST_CELL) begin
          cell_r <= '0;
          if (row_r == LAST_ROW) begin
            row_r <= '0;
          end else begin
            row_r <= row_r + ROW_W'(1);
          end
        end else begin
          cell_r <= cell_r + CELL_W'(1);
        end
      end else begin
        bin_r <= bin_r + BIN_ADDR_W'(1);
      end
    end
  end

  // Even rows land in buffer A, odd rows in buffer B.
  cell_row_ram #(.ADDR_W(ADDR_W), .DATA_W(VALUE_W)) u_buf_a (
    .pclk    (pclk),
    .we      (deIn & ~row_r[0]),
    .wr_addr ({cell_r, bin_r}),
    .din     (histValueIn),
    .re      (rd_en_s),
    .rd_addr (rd_addr_s),
    .dout    (dout_a_s)
  );

  cell_row_ram #(.ADDR_W(ADDR_W), .DATA_W(VALUE_W)) u_buf_b (
    .pclk    (pclk),
    .we      (deIn & row_r[0]),
    .wr_addr ({cell_r, bin_r}),
    .din     (histValueIn),
    .re      (rd_en_s),
    .rd_addr (rd_addr_s),
    .dout    (dout_b_s)
  );

  // Read address generation: quadrants 0/1 come from the previous row, 2/3 from
  // the current one; odd quadrants take the right-hand cell of the block.
  always_comb begin
    rd_en_s   = (state_r == EMIT);
    rd_cell_s = j_r + CELL_W'(q_r[0]);
    rd_addr_s = {rd_cell_s, b_r};
    if (q_r[1]) begin
      rd_sel_s = cur_sel_r;
    end else begin
      rd_sel_s = ~cur_sel_r;
    end
    if ((state_r == EMIT) && (j_r == LAST_BLOCK) && (q_r == 2'd3) && is_last_bin(b_r)) begin
      final_s = 1'b1;
    end else begin
      final_s = 1'b0;
    end
    if (row_done_s && (row_r != ROW_W'(0)) && (state_r == IDLE)) begin
      trigger_s = 1'b1;
    end else begin
      trigger_s = 1'b0;
    end
  end

  // Emission FSM with its loop counters, busy and the sticky overrun flag.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_r   <= IDLE;
      j_r       <= '0;
      q_r       <= '0;
      b_r       <= '0;
      cur_sel_r <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= trigger_s | (state_r == EMIT) | p1_valid_r;
      // The final read cycle may overlap the first beat of the next row.
      if (deIn && (state_r == EMIT) && !final_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_r   <= EMIT;
            j_r       <= '0;
            q_r       <= '0;
            b_r       <= '0;
            cur_sel_r <= row_r[0];
          end
        end
        EMIT: begin
          if (is_last_bin(b_r)) begin
            b_r <= '0;
            if (q_r == 2'd3) begin
              q_r <= 2'd0;
              if (j_r == LAST_BLOCK) begin
                j_r     <= '0;
                state_r <= IDLE;
              end else begin
                j_r <= j_r + CELL_W'(1);
              end
            end else begin
              q_r <= q_r + 2'd1;
            end
          end else begin
            b_r <= b_r + BIN_ADDR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pick the buffer that was read and fold the element into the block sum.
  always_comb begin
    if (p1_sel_r) begin
      rd_data_s = dout_b_s;
    end else begin
      rd_data_s = dout_a_s;
    end
    if (p1_first_r) begin
      sum_s = SUM_W'(rd_data_s);
    end else begin
      sum_s = acc_r + SUM_W'(rd_data_s);
    end
  end

  // Read pipeline: flags follow the RAM latency, then register all outputs.
  always_ff @(posedge pclk) begin
    if (reset) begin
      p1_valid_r <= 1'b0;
      p1_sel_r   <= 1'b0;
      p1_first_r <= 1'b0;
      p1_last_r  <= 1'b0;
      acc_r      <= '0;
      value_r    <= '0;
      de_r       <= 1'b0;
      start_r    <= 1'b0;
      end_r      <= 1'b0;
      sum_out_r  <= '0;
    end else begin
      p1_valid_r <= rd_en_s;
      p1_sel_r   <= rd_sel_s;
      p1_first_r <= rd_en_s && (q_r == 2'd0) && (b_r == BIN_ADDR_W'(0));
      p1_last_r  <= rd_en_s && (q_r == 2'd3) && is_last_bin(b_r);
      de_r       <= p1_valid_r;
      start_r    <= p1_valid_r & p1_first_r;
      end_r      <= p1_valid_r & p1_last_r;
      if (p1_valid_r) begin
        value_r <= rd_data_s;
        acc_r   <= sum_s;
      end else begin
        value_r <= '0;
      end
      if (p1_valid_r && p1_last_r) begin
        sum_out_r <= sum_s;
      end else begin
        sum_out_r <= '0;
      end
    end
  end

  assign valueOut    = value_r;
  assign deOut       = de_r;
  assign blockStart  = start_r;
  assign blockEnd    = end_r;
  assign blockSumOut = sum_out_r;
  assign busy        = busy_r;
  assign overrunErr  = overrun_r;

endmodule

// File: tb/tb_hog_block_assembler.sv
// Randomized scoreboard bench for hog_block_assembler with a block-level
// reference model of the row buffers and emission windows.
module tb_hog_block_assembler;

  localparam int C    = 8;
  localparam int R    = 16;
  localparam int NOUT = 36 * (C - 1);
  localparam int VMAX = 262143;

  logic        pclk;
  logic        reset;
  logic [17:0] histValueIn;
  logic        deIn;
  logic [17:0] valueOut;
  logic        deOut;
  logic        blockStart;
  logic        blockEnd;
  logic [23:0] blockSumOut;
  logic        busy;
  logic        overrunErr;

  hog_block_assembler #(.CELLS_IN_LINE(C), .CELL_ROWS(R)) dut (
    .pclk        (pclk),
    .reset       (reset),
    .histValueIn (histValueIn),
    .deIn        (deIn),
    .valueOut    (valueOut),
    .deOut       (deOut),
    .blockStart  (blockStart),
    .blockEnd    (blockEnd),
    .blockSumOut (blockSumOut),
    .busy        (busy),
    .overrunErr  (overrunErr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int v;
    bit s;
    bit e;
    int sum;
  } exp_t;

  exp_t expq[$];
  int   mem_m [2][C][9];
  int   m_bin, m_cell, m_row;
  int   trig = -1000;
  bit   exp_ovr;
  int   cyc;
  int   checks;
  int   errors;
  int   pop_count;
  int   obs_val [256];
  int   obs_sum [256];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build the full block stream for a completed row from the model buffers.
  function automatic void push_blocks(input int cur);
    int s;
    int bufsel;
    exp_t e;
    for (int j = 0; j < C - 1; j++) begin
      s = 0;
      for (int q = 0; q < 4; q++) begin
        bufsel = (q < 2) ? (1 - cur) : cur;
        for (int b = 0; b < 9; b++) begin
          e.v   = mem_m[bufsel][j + (q % 2)][b];
          s     = s + e.v;
          e.s   = (q == 0 && b == 0);
          e.e   = (q == 3 && b == 8);
          e.sum = e.e ? s : 0;
          expq.push_back(e);
        end
      end
    end
  endfunction

  // Reference model: observes the bench's own stimulus at each clock edge.
  always @(posedge pclk) begin
    if (reset) begin
      m_bin = 0; m_cell = 0; m_row = 0;
      expq.delete();
      trig = -1000;
      exp_ovr = 0;
    end else if (deIn) begin
      mem_m[m_row % 2][m_cell][m_bin] = int'(histValueIn);
      if (cyc >= trig + 1 && cyc <= trig + NOUT - 1) exp_ovr = 1;
      if (m_bin == 8 && m_cell == C - 1 && m_row != 0 &&
          !(cyc >= trig + 1 && cyc <= trig + NOUT)) begin
        trig = cyc;
        push_blocks(m_row % 2);
      end
      if (m_bin == 8) begin
        m_bin = 0;
        if (m_cell == C - 1) begin
          m_cell = 0;
          m_row = (m_row == R - 1) ? 0 : m_row + 1;
        end else begin
          m_cell++;
        end
      end else begin
        m_bin++;
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: check control timing every cycle, pop and compare on deOut.
  always @(negedge pclk) begin
    bit exp_de, exp_busy;
    exp_t e;
    exp_de   = (cyc >= trig + 3) && (cyc <= trig + NOUT + 2);
    exp_busy = (cyc >= trig + 1) && (cyc <= trig + NOUT + 2);
    chk("de_busy_ovr", {deOut, busy, overrunErr}, {exp_de, exp_busy, exp_ovr});
    if (deOut) begin
      if (expq.size() == 0) begin
        chk("deOut_extra", deOut, 0);
      end else begin
        e = expq.pop_front();
        chk("valueOut", valueOut, e.v);
        chk("blockStart", blockStart, e.s);
        chk("blockEnd", blockEnd, e.e);
        chk("blockSumOut", blockSumOut, e.sum);
        if (pop_count < 256) begin
          obs_val[pop_count] = int'(valueOut);
          obs_sum[pop_count] = int'(blockSumOut);
        end
        pop_count++;
      end
    end
  end

  task automatic beat(input int v);
    @(posedge pclk); #1;
    deIn = 1'b1;
    histValueIn = 18'(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      deIn = 1'b0;
      histValueIn = 18'(0);
    end
  endtask

  // mode 0: 1000*r+10*cell+bin, 1: all ones, 2: random.
  task automatic feed_row(input int r, input int mode, input bit gaps);
    int v;
    for (int c = 0; c < C; c++) begin
      for (int b = 0; b < 9; b++) begin
        if (gaps && $urandom_range(0, 5) == 0) idle(1);
        case (mode)
          0:       v = 1000 * r + 10 * c + b;
          1:       v = VMAX;
          default: v = int'($urandom_range(0, VMAX));
        endcase
        beat(v);
      end
    end
    idle(1);
  endtask

  task automatic rst_now();
    reset = 1'b1;
    deIn = 1'b0;
    @(negedge pclk);
    chk("reset_outputs", {valueOut, deOut, blockStart, blockEnd, blockSumOut, busy, overrunErr}, 0);
    reset = 1'b0;
    pop_count = 0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_now();
  endtask

  task automatic check_exact(input string tag);
    chk({tag, "_v0"},   obs_val[0], 0);
    chk({tag, "_v8"},   obs_val[8], 8);
    chk({tag, "_v9"},   obs_val[9], 10);
    chk({tag, "_v18"},  obs_val[18], 1000);
    chk({tag, "_v35"},  obs_val[35], 1018);
    chk({tag, "_sum0"}, obs_sum[35], 18324);
    chk({tag, "_b6"},   obs_val[216], 60);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    deIn = 1'b0;
    histValueIn = 18'(0);
    checks = 0;
    errors = 0;
    pop_count = 0;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;

    // Row 0 alone emits nothing.
    do_reset();
    feed_row(0, 0, 1'b0);
    idle(30);
    chk("row0_count", pop_count, 0);

    // Exact values, then a new row starting on the final read cycle.
    do_reset();
    feed_row(0, 0, 1'b0);
    feed_row(1, 0, 1'b0);
    idle(250);
    feed_row(2, 2, 1'b0);
    idle(300);
    check_exact("exact");
    chk("exact_count", pop_count, 2 * NOUT);

    // Saturated inputs.
    do_reset();
    feed_row(0, 1, 1'b0);
    feed_row(1, 1, 1'b0);
    idle(260);
    chk("sat_sum_first", obs_sum[35], 9437148);
    chk("sat_sum_last", obs_sum[NOUT - 1], 9437148);

    // Frame wrap over 17 rows with random data and gaps.
    do_reset();
    for (int r = 0; r < 17; r++) begin
      feed_row(r, 2, 1'b1);
      idle(260);
    end
    chk("wrap_count", pop_count, 15 * NOUT);

    // Overrun: row 2 (same data as row 0) arrives during emission.
    do_reset();
    feed_row(0, 0, 1'b0);
    feed_row(1, 0, 1'b0);
    idle(9);
    feed_row(0, 0, 1'b0);
    idle(260);
    @(negedge pclk);
    chk("ovr_flag", overrunErr, 1);
    chk("ovr_lost_count", pop_count, NOUT);
    feed_row(3, 2, 1'b0);
    idle(260);
    @(negedge pclk);
    chk("ovr_sticky", overrunErr, 1);
    chk("ovr_count", pop_count, 2 * NOUT);

    // Reset in the middle of an emission, then a fresh run.
    do_reset();
    feed_row(0, 0, 1'b0);
    feed_row(1, 0, 1'b0);
    guard = 0;
    while (pop_count < 100 && guard < 2000) begin
      @(negedge pclk);
      guard++;
    end
    chk("mid_reached", pop_count, 100);
    rst_now();
    idle(20);
    chk("mid_no_output", pop_count, 0);
    feed_row(0, 0, 1'b0);
    feed_row(1, 0, 1'b0);
    idle(260);
    check_exact("rerun");
    chk("rerun_count", pop_count, NOUT);

    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
